// File: rtl/readout_pkg.sv
// Shared definitions for the event reader command interface and the readout framer.
package readout_pkg;

    localparam logic [7:0]  CMD_NOP           = 8'h00;
    localparam logic [7:0]  CMD_LO            = 8'h01;
    localparam logic [7:0]  CMD_HI            = 8'h02;
    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        REQ,
        WAIT,
        SEND,
        CSUM
    } frm_state_t;

    // Odd halves re-read the word already popped, so only even halves depend on the FIFO flag.
    function automatic logic [7:0] half_cmd(input logic [4:0] half, input logic empty);
        if (half[0]) begin
            return CMD_HI;
        end
        return empty ? CMD_NOP : CMD_LO;
    endfunction

endpackage

// File: rtl/byte_shifter.sv
// Loads a 32-bit field and emits its bytes MSB-first on a valid/ready stream.
module byte_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  last_idx_i,
    input  logic        ready_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        done_o,
    output logic [1:0]  idx_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic        valid_q, valid_d;
    logic        accept;

    assign accept  = valid_q && ready_i;
    assign done_o  = accept && (idx_q == last_q);
    assign data_o  = shift_q[31:24];
    assign valid_o = valid_q;
    assign idx_o   = idx_q;

    // A load wins over an accept so a new field can follow the last byte with no gap.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = data_i;
            idx_d   = 2'd0;
            last_d  = last_idx_i;
            valid_d = 1'b1;
        end else if (accept) begin
            if (idx_q == last_q) begin
                valid_d = 1'b0;
            end else begin
                shift_d = {shift_q[23:0], 8'h00};
                idx_d   = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/readout_framer.sv
// Pulls events half-word by half-word from the event reader and frames them
// as sync, counter, payload and XOR checksum bytes toward the host link.
module readout_framer
    import readout_pkg::*;
#(
    parameter int          WORDS_PER_EVENT = 16,
    parameter int          RD_LAT          = 2,
    parameter logic [15:0] SYNC_WORD       = SYNC_WORD_DEFAULT
) (
    input  logic        f125_clk,
    input  logic        aresetn,
    input  logic        start_i,
    input  logic        empty_i,
    input  logic [31:0] event_half_i,
    output logic [7:0]  cmd_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic [15:0] evt_count_o
);

    localparam logic [4:0] LAST_HALF = 5'(2 * WORDS_PER_EVENT - 1);
    localparam int         WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    frm_state_t        state_q, state_d;
    logic [4:0]        half_q, half_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              busy_q, busy_d;
    logic [15:0]       count_q, count_d;

    logic              sh_load;
    logic [31:0]       sh_data;
    logic [1:0]        sh_last;
    logic              sh_done;
    logic [1:0]        sh_idx;
    logic              sh_valid;
    logic [7:0]        sh_byte;
    logic              sum_byte;
    logic [7:0]        csum_acc;

    byte_shifter u_shifter (
        .clk        (f125_clk),
        .rst_n      (aresetn),
        .load_i     (sh_load),
        .data_i     (sh_data),
        .last_idx_i (sh_last),
        .ready_i    (tx_ready_i),
        .data_o     (sh_byte),
        .valid_o    (sh_valid),
        .done_o     (sh_done),
        .idx_o      (sh_idx)
    );

    // Counter bytes (second half of the header) and payload bytes feed the checksum.
    assign sum_byte = sh_valid && tx_ready_i &&
                      ((state_q == SEND) || ((state_q == HDR) && (sh_idx >= 2'd2)));
    assign csum_acc = sum_byte ? (csum_q ^ sh_byte) : csum_q;

    always_ff @(posedge f125_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            half_q  <= '0;
            wait_q  <= '0;
            csum_q  <= '0;
            cmd_q   <= CMD_NOP;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            wait_q  <= wait_d;
            csum_q  <= csum_d;
            cmd_q   <= cmd_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i && !empty_i) state_d = HDR;
            HDR:  if (sh_done) state_d = REQ;
            REQ:  if (cmd_q != CMD_NOP) state_d = WAIT;
            WAIT: if (wait_q == WAIT_W'(RD_LAT - 1)) state_d = SEND;
            SEND: if (sh_done) state_d = (half_q == LAST_HALF) ? CSUM : REQ;
            CSUM: if (sh_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so each command
    // pulse coincides with the REQ cycle and each field's first byte with its first cycle.
    always_comb begin
        half_d  = half_q;
        wait_d  = wait_q;
        csum_d  = csum_acc;
        busy_d  = busy_q;
        count_d = count_q;
        sh_load = 1'b0;
        sh_data = '0;
        sh_last = 2'd3;
        case (state_q)
            IDLE: begin
                if (state_d == HDR) begin
                    sh_load = 1'b1;
                    sh_data = {SYNC_WORD, count_q};
                    csum_d  = 8'h00;
                    half_d  = 5'd0;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (state_d == SEND) begin
                    sh_load = 1'b1;
                    sh_data = event_half_i;
                    wait_d  = '0;
                end
            end
            SEND: begin
                if (state_d == REQ) begin
                    half_d = half_q + 5'd1;
                end else if (state_d == CSUM) begin
                    sh_load = 1'b1;
                    sh_data = {csum_acc, 24'h000000};
                    sh_last = 2'd0;
                end
            end
            CSUM: begin
                if (sh_done) begin
                    busy_d  = 1'b0;
                    count_d = count_q + 16'd1;
                end
            end
            default: ;
        endcase
        cmd_d = (state_d == REQ) ? half_cmd(half_d, empty_i) : CMD_NOP;
    end

    assign cmd_o       = cmd_q;
    assign busy_o      = busy_q;
    assign evt_count_o = count_q;
    assign tx_data_o   = sh_byte;
    assign tx_valid_o  = sh_valid;

endmodule
